router_input_arbiter: RTL and testbench

- Merge stage at the output side of a mesh router port.
- Collects AXI-Stream packets from CHANNEL_NUMBER source channels (local + N/E/S/W) and serialises them onto one outgoing link.
- Arbitration is round-robin at packet granularity. A grant is held from the first beat until the TLAST beat, so packets never interleave.
- Output is a registered stage with full-throughput backpressure.

---
 rtl/router_input_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_router_input_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_arbiter.sv
// ---------------------------------------------------------------------------
// router_input_arbiter
//
// Merge stage on the output side of a mesh router port. Several AXI-Stream
// source channels (local + N/E/S/W) are serialised onto one outgoing link.
// Arbitration is round-robin at packet granularity: once a channel wins with
// a non-TLAST beat, it keeps the grant until its TLAST beat is accepted, so
// packets never interleave. The outgoing link is driven from a single
// register stage that still sustains one beat per cycle under TREADY=1.
//
// Ports
//   ACLK        clock, rising edge
//   ARESET      synchronous, active-high reset
//   in_tvalid   [CHANNEL_NUMBER]          per-channel TVALID
//   in_tready   [CHANNEL_NUMBER]          per-channel TREADY (combinational)
//   in_tdata    [CHANNEL_NUMBER][DATA]    per-channel TDATA
//   in_tlast    [CHANNEL_NUMBER]          per-channel TLAST
//   in_tid/in_tdest/in_tuser              optional, under TID/TDEST/TUSER_PRESENT
//   out_tvalid/out_tready/out_tdata/out_tlast (+ optional fields)  merged link
//   grant_idx   channel holding the grant (meaningful while busy=1)
//   busy        high while a multi-beat packet holds the lock
// ---------------------------------------------------------------------------
module router_input_arbiter #(
    parameter int DATA_WIDTH           = 32,
    parameter int ID_WIDTH             = 4,
    parameter int DEST_WIDTH           = 4,
    parameter int USER_WIDTH           = 4,
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic                                        ACLK,
    input  logic                                        ARESET,
    input  logic [CHANNEL_NUMBER-1:0]                   in_tvalid,
    output logic [CHANNEL_NUMBER-1:0]                   in_tready,
    input  logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0]   in_tdata,
    input  logic [CHANNEL_NUMBER-1:0]                   in_tlast,
`ifdef TID_PRESENT
    input  logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]     in_tid,
    output logic [ID_WIDTH-1:0]                         out_tid,
`endif
`ifdef TDEST_PRESENT
    input  logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0]   in_tdest,
    output logic [DEST_WIDTH-1:0]                       out_tdest,
`endif
`ifdef TUSER_PRESENT
    input  logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0]   in_tuser,
    output logic [USER_WIDTH-1:0]                       out_tuser,
`endif
    output logic                                        out_tvalid,
    input  logic                                        out_tready,
    output logic [DATA_WIDTH-1:0]                       out_tdata,
    output logic                                        out_tlast,
    output logic [CHANNEL_NUMBER_WIDTH-1:0]             grant_idx,
    output logic                                        busy
);

    // Optional sideband fields only contribute to the payload when enabled.
`ifdef TID_PRESENT
    localparam bit HAS_ID = 1'b1;
`else
    localparam bit HAS_ID = 1'b0;
`endif
`ifdef TDEST_PRESENT
    localparam bit HAS_DEST = 1'b1;
`else
    localparam bit HAS_DEST = 1'b0;
`endif
`ifdef TUSER_PRESENT
    localparam bit HAS_USER = 1'b1;
`else
    localparam bit HAS_USER = 1'b0;
`endif

    localparam int ID_BITS       = HAS_ID   ? ID_WIDTH   : 0;
    localparam int DEST_BITS     = HAS_DEST ? DEST_WIDTH : 0;
    localparam int USER_BITS     = HAS_USER ? USER_WIDTH : 0;
    // Payload layout (MSB..LSB): user, dest, id, last, data.
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + 1 + ID_BITS + DEST_BITS + USER_BITS;
    localparam int CW            = CHANNEL_NUMBER_WIDTH;
    // Pointer starts at the last channel so channel 0 is searched first.
    localparam logic [CW-1:0] PTR_RESET = CW'(CHANNEL_NUMBER - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                                        state_r;
    state_t                                        state_nxt_s;
    logic [CW-1:0]                                 ptr_r;
    logic [CW-1:0]                                 ptr_nxt_s;
    logic [CW-1:0]                                 grant_r;
    logic [CW-1:0]                                 grant_nxt_s;

    logic                                          out_v_r;
    logic [PAYLOAD_WIDTH-1:0]                      out_payload_r;

    logic [CHANNEL_NUMBER-1:0][PAYLOAD_WIDTH-1:0]  in_payload_s;
    logic                                          can_load_s;
    logic                                          cand_found_s;
    logic [CW-1:0]                                 cand_idx_s;
    logic                                          sel_en_s;
    logic [CW-1:0]                                 sel_idx_s;
    logic                                          sel_tvalid_s;
    logic [PAYLOAD_WIDTH-1:0]                      sel_payload_s;
    logic                                          sel_tlast_s;
    logic                                          hs_s;

    // Round-robin search: first requester strictly after ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [CW:0] rr_pick(
        input logic [CHANNEL_NUMBER-1:0] req,
        input logic [CW-1:0]             ptr
    );
        logic          found;
        logic [CW-1:0] idx;
        logic [CW-1:0] pos_idx;
        int            pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
            pos = int'(ptr) + k;
            if (pos >= CHANNEL_NUMBER) begin
                pos = pos - CHANNEL_NUMBER;
            end else begin
                pos = pos;
            end
            pos_idx = CW'(pos);
            if (!found && req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Pack each channel's forwarded fields into one payload word.
    always_comb begin
        in_payload_s = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            in_payload_s[i] = {
`ifdef TUSER_PRESENT
                in_tuser[i],
`endif
`ifdef TDEST_PRESENT
                in_tdest[i],
`endif
`ifdef TID_PRESENT
                in_tid[i],
`endif
                in_tlast[i],
                in_tdata[i]
            };
        end
    end

    // Channel selection: locked channel while busy, else round-robin candidate.
    always_comb begin
        can_load_s                  = !out_v_r || out_tready;
        {cand_found_s, cand_idx_s}  = rr_pick(in_tvalid, ptr_r);
        if (state_r == ST_LOCKED) begin
            sel_en_s  = 1'b1;
            sel_idx_s = grant_r;
        end else begin
            sel_en_s  = cand_found_s;
            sel_idx_s = cand_idx_s;
        end
        sel_tvalid_s  = 1'b0;
        sel_payload_s = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            if (sel_idx_s == CW'(i)) begin
                sel_tvalid_s  = in_tvalid[i];
                sel_payload_s = in_payload_s[i];
            end else begin
                sel_tvalid_s  = sel_tvalid_s;
            end
        end
        sel_tlast_s = sel_payload_s[DATA_WIDTH];
        // A stalled locked channel (TVALID low) simply produces no handshake.
        hs_s = !ARESET && sel_en_s && can_load_s && sel_tvalid_s;
    end

    // Next-state logic for the lock FSM, round-robin pointer and grant index.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    ptr_nxt_s   = sel_idx_s;
                    grant_nxt_s = sel_idx_s;
                    // Single-beat packets never lock; next search starts at g+1.
                    if (sel_tlast_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (hs_s && sel_tlast_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register for the FSM, pointer and grant.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_RESET;
            grant_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Output register: load on handshake, otherwise drain on TREADY, else hold.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            out_v_r       <= 1'b0;
            out_payload_r <= '0;
        end else if (hs_s) begin
            out_v_r       <= 1'b1;
            out_payload_r <= sel_payload_s;
        end else if (out_tready) begin
            out_v_r       <= 1'b0;
        end else begin
            out_v_r       <= out_v_r;
        end
    end

    // FSM outputs: per-channel TREADY and status flags.
    always_comb begin
        busy      = (state_r == ST_LOCKED);
        grant_idx = grant_r;
        in_tready = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            if (!ARESET && sel_en_s && can_load_s && (sel_idx_s == CW'(i))) begin
                in_tready[i] = 1'b1;
            end else begin
                in_tready[i] = 1'b0;
            end
        end
    end

    assign out_tvalid = out_v_r;
    assign {
`ifdef TUSER_PRESENT
        out_tuser,
`endif
`ifdef TDEST_PRESENT
        out_tdest,
`endif
`ifdef TID_PRESENT
        out_tid,
`endif
        out_tlast,
        out_tdata
    } = out_payload_r;

endmodule

// File: tb/tb_router_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_input_arbiter
//
// Scoreboard bench for router_input_arbiter. Per-channel source queues feed
// beats (entries with v=0 are one-cycle TVALID gaps); expected output beats
// are pushed in the order the arbitration rules dictate and popped by a
// monitor on every output handshake. Scenario tasks add targeted checks.
// ---------------------------------------------------------------------------
module tb_router_input_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int CW = 3;

    logic                 ACLK;
    logic                 ARESET;
    logic [N-1:0]         in_tvalid;
    logic [N-1:0]         in_tready;
    logic [N-1:0][DW-1:0] in_tdata;
    logic [N-1:0]         in_tlast;
    logic                 out_tvalid;
    logic                 out_tready;
    logic [DW-1:0]        out_tdata;
    logic                 out_tlast;
    logic [CW-1:0]        grant_idx;
    logic                 busy;

    int checks;
    int errors;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    beat_t src_q[N][$];
    exp_t  exp_q[$];

    router_input_arbiter #(
        .DATA_WIDTH     (DW),
        .CHANNEL_NUMBER (N)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit src_pending();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_src(input int ch, input logic v, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.v = v;
        b.d = d;
        b.l = l;
        src_q[ch].push_back(b);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    // Presents queue heads; pops a head after its handshake (or after a gap cycle).
    task automatic driver_loop();
        logic [N-1:0] pop;
        forever begin
            @(negedge ACLK);
            for (int i = 0; i < N; i++) begin
                pop[i] = 1'b0;
                if (src_q[i].size() != 0) begin
                    if (!src_q[i][0].v || (in_tvalid[i] && in_tready[i])) pop[i] = 1'b1;
                end
            end
            @(posedge ACLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0) begin
                    in_tvalid[i] = src_q[i][0].v;
                    in_tdata[i]  = src_q[i][0].v ? src_q[i][0].d : '0;
                    in_tlast[i]  = src_q[i][0].v ? src_q[i][0].l : 1'b0;
                end else begin
                    in_tvalid[i] = 1'b0;
                    in_tdata[i]  = '0;
                    in_tlast[i]  = 1'b0;
                end
            end
        end
    endtask

    // Scoreboard: every accepted output beat must match the next expected beat.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARESET && out_tvalid === 1'b1 && out_tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: unexpected beat data=%h last=%b", out_tdata, out_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (out_tdata !== e.d || out_tlast !== e.l) begin
                        errors++;
                        $display("FAIL out_beat: got data=%h last=%b expected data=%h last=%b",
                                 out_tdata, out_tlast, e.d, e.l);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < max) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL drain: %0d expected beats still pending after %0d cycles, required 0",
                     exp_q.size(), max);
            clear_queues();
        end
    endtask

    task automatic wait_hs(input int ch, input int max, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            @(negedge ACLK);
            n++;
            if (in_tvalid[ch] && in_tready[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge ACLK);
        #1;
        ARESET     = 1'b1;
        out_tready = 1'b1;
        clear_queues();
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        push_src(3, 1'b1, 32'h33, 1'b1);
        repeat (3) @(negedge ACLK);
        checks++;
        if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", out_tvalid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_idx); end
        checks++;
        if (in_tready !== 5'b00000) begin errors++; $display("FAIL reset_tready: got %b expected 00000", in_tready); end
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        push_exp(32'h33, 1'b1);
        wait_drain(20);
    endtask

    task automatic test_single_beat();
        bit ok;
        @(negedge ACLK);
        push_src(2, 1'b1, 32'hA5, 1'b1);
        push_exp(32'hA5, 1'b1);
        wait_hs(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_hs: got no handshake expected one on in[2]"); end
        @(negedge ACLK);
        checks++;
        if (out_tvalid !== 1'b1) begin errors++; $display("FAIL single_latency: tvalid got %b expected 1", out_tvalid); end
        checks++;
        if (out_tdata !== 32'hA5 || out_tlast !== 1'b1) begin
            errors++;
            $display("FAIL single_data: got %h/%b expected a5/1", out_tdata, out_tlast);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
        wait_drain(20);
    endtask

    task automatic test_two_packets();
        bit ok;
        apply_reset();
        for (int b = 0; b < 3; b++) push_src(0, 1'b1, 32'h10 + 32'(b), (b == 2));
        for (int b = 0; b < 3; b++) push_src(3, 1'b1, 32'h30 + 32'(b), (b == 2));
        for (int b = 0; b < 3; b++) push_exp(32'h10 + 32'(b), (b == 2));
        for (int b = 0; b < 3; b++) push_exp(32'h30 + 32'(b), (b == 2));
        wait_hs(0, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL two_first_hs: got no handshake expected in[0] first"); end
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b1 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL two_lock0: busy/grant got %b/%0d expected 1/0", busy, grant_idx);
        end
        checks++;
        if (in_tready[3] !== 1'b0) begin errors++; $display("FAIL two_block3: in[3] tready got %b expected 0", in_tready[3]); end
        wait_hs(3, 20, ok);
        checks++;
        if (!ok || src_q[0].size() != 0) begin
            errors++;
            $display("FAIL two_no_interleave: in[3] hs=%b with %0d in[0] beats left, expected 1 with 0", ok, src_q[0].size());
        end
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b1 || grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL two_lock3: busy/grant got %b/%0d expected 1/3", busy, grant_idx);
        end
        wait_drain(30);
    endtask

    task automatic test_round_robin();
        int  n;
        int  cnt;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < N; ch++) begin
                push_src(ch, 1'b1, 32'h200 + 32'(16 * r + ch), 1'b1);
                push_exp(32'h200 + 32'(16 * r + ch), 1'b1);
            end
        end
        n = 0;
        while (out_tvalid !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_tvalid === 1'b1 && out_tready === 1'b1) cnt++;
            @(negedge ACLK);
        end
        checks++;
        if (cnt != 10) begin errors++; $display("FAIL rr_throughput: got %0d beats in 10 cycles expected 10", cnt); end
        wait_drain(20);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge ACLK);
        for (int b = 0; b < 4; b++) begin
            push_src(1, 1'b1, 32'h50 + 32'(b), (b == 3));
            push_exp(32'h50 + 32'(b), (b == 3));
        end
        n = 0;
        while (out_tvalid !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        @(posedge ACLK);
        #1;
        out_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            checks++;
            if (out_tvalid !== 1'b1 || out_tdata !== 32'h51 || out_tlast !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable: cycle %0d got %b/%h/%b expected 1/51/0", k, out_tvalid, out_tdata, out_tlast);
            end
            checks++;
            if (in_tready[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_tready: cycle %0d in[1] tready got %b expected 0", k, in_tready[1]);
            end
        end
        @(posedge ACLK);
        #1;
        out_tready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_lock_hold();
        int n;
        int gaps;
        bit viol;
        bit seen_last;
        @(negedge ACLK);
        push_src(4, 1'b1, 32'h70, 1'b0);
        push_src(4, 1'b1, 32'h71, 1'b0);
        push_src(4, 1'b0, 32'h0, 1'b0);
        push_src(4, 1'b0, 32'h0, 1'b0);
        push_src(4, 1'b1, 32'h72, 1'b1);
        push_exp(32'h70, 1'b0);
        push_exp(32'h71, 1'b0);
        push_exp(32'h72, 1'b1);
        n = 0;
        while (!(busy === 1'b1 && grant_idx === 3'd4) && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        push_src(0, 1'b1, 32'h80, 1'b1);
        push_exp(32'h80, 1'b1);
        gaps      = 0;
        viol      = 1'b0;
        seen_last = 1'b0;
        n         = 0;
        while (!seen_last && n < 40) begin
            @(negedge ACLK);
            n++;
            if (in_tvalid[4] && in_tready[4] && in_tlast[4]) begin
                seen_last = 1'b1;
            end else begin
                if (in_tready[0]) viol = 1'b1;
                if (!in_tvalid[4] && busy) gaps++;
            end
        end
        checks++;
        if (!seen_last) begin errors++; $display("FAIL lock_last: in[4] TLAST never accepted"); end
        checks++;
        if (viol) begin errors++; $display("FAIL lock_block: in[0] tready got 1 during lock expected 0"); end
        checks++;
        if (gaps != 2) begin errors++; $display("FAIL lock_gap: got %0d locked gap cycles expected 2", gaps); end
        @(negedge ACLK);
        checks++;
        if (in_tready[0] !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lock_next: in[0] tready/busy got %b/%b expected 1/0", in_tready[0], busy);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid_packet();
        int n;
        bit ok;
        @(posedge ACLK);
        #1;
        out_tready = 1'b0;
        @(negedge ACLK);
        for (int b = 0; b < 3; b++) push_src(2, 1'b1, 32'hA0 + 32'(b), (b == 2));
        n = 0;
        while (!(busy === 1'b1 && out_tvalid === 1'b1) && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL rst_mid_setup: busy/tvalid got %b/%b expected 1/1", busy, out_tvalid); end
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        clear_queues();
        @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (out_tvalid !== 1'b0 || busy !== 1'b0 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_state: tvalid/busy/grant got %b/%b/%0d expected 0/0/0", out_tvalid, busy, grant_idx);
        end
        @(posedge ACLK);
        #1;
        ARESET     = 1'b0;
        out_tready = 1'b1;
        @(negedge ACLK);
        push_src(3, 1'b1, 32'h93, 1'b1);
        push_src(0, 1'b1, 32'h90, 1'b1);
        push_exp(32'h90, 1'b1);
        push_exp(32'h93, 1'b1);
        wait_hs(0, 20, ok);
        checks++;
        if (!ok || in_tready[3] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_prio: in[0] hs=%b in[3] tready=%b expected 1/0", ok, in_tready[3]);
        end
        wait_drain(20);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        ARESET     = 1'b1;
        out_tready = 1'b1;
        in_tvalid  = '0;
        in_tdata   = '0;
        in_tlast   = '0;
        fork
            driver_loop();
            monitor_loop();
        join_none
        test_reset();
        test_single_beat();
        test_two_packets();
        test_round_robin();
        test_backpressure();
        test_lock_hold();
        test_reset_mid_packet();
        repeat (3) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
